// File: rtl/register_bus_arbiter.sv
// rtl/register_bus_arbiter.sv - round-robin owner arbiter for a shared tri-state register bus
//
// Grants one register at a time the right to drive the shared output bus and
// inserts a one-tick turnaround between owners. All state advances only on Tick.
// Optional feature macro: ARB_TIMEOUT_EN adds the grant-hold counter and the
// forced release that pulses Timeout.
//
// Ports:
//   Clock     rising-edge system clock
//   Reset     asynchronous, active-high reset
//   Tick      global clock enable for the FSM and counter
//   Req       per-requester level bus request
//   Done      per-requester transfer-complete strobe, only the owner's bit matters
//   Grant     one-hot registered grant
//   Cs        per-register chip select, ~Grant (1 = register output floats)
//   GrantIdx  binary index of the current owner, 0 when there is no owner
//   BusBusy   1 while a grant or the turnaround tick is in progress
//   Timeout   one-clock pulse when a grant is force-released
module register_bus_arbiter #(
  parameter int NrOfRequesters = 4,
  parameter int IdxBits        = 2,
  parameter int GrantTimeout   = 15,
  parameter int CntBits        = 8
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Tick,
  input  logic [NrOfRequesters-1:0] Req,
  input  logic [NrOfRequesters-1:0] Done,
  output logic [NrOfRequesters-1:0] Grant,
  output logic [NrOfRequesters-1:0] Cs,
  output logic [IdxBits-1:0]        GrantIdx,
  output logic                      BusBusy,
  output logic                      Timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [NrOfRequesters-1:0] OneHotLsb = NrOfRequesters'(1);
  localparam logic [IdxBits-1:0]        LastReset = IdxBits'(NrOfRequesters - 1);

  state_t                    state;
  logic [IdxBits-1:0]        last_idx;
  logic [IdxBits-1:0]        next_idx;
  logic                      next_found;
  logic [NrOfRequesters-1:0] req_rot;
  int                        cand;
  logic                      owner_done;
  logic                      owner_req;

  // Cs is derived from the reset-cleared Grant register, so an asynchronous
  // reset floats every register output without waiting for a clock edge.
  assign Cs = ~Grant;

  // Grant is one-hot, so masking picks out only the owner's Done/Req bits.
  assign owner_done = |(Done & Grant);
  assign owner_req  = |(Req & Grant);

  // Round-robin search: first set Req bit at last_idx+1, last_idx+2, ... with wrap.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    req_rot    = '0;
    cand       = 0;
    for (int i = 1; i <= NrOfRequesters; i++) begin
      cand    = (int'(last_idx) + i) % NrOfRequesters;
      req_rot = Req >> cand;
      if (!next_found && req_rot[0]) begin
        next_found = 1'b1;
        next_idx   = IdxBits'(cand);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CntBits-1:0] TimeoutLast = CntBits'(GrantTimeout - 1);
  logic [CntBits-1:0] hold_cnt;
`else
  // Hold parameters are referenced so both builds accept the same parameter list.
  localparam bit HoldCfgValid = (GrantTimeout > 0) && (CntBits > 0);
  assign Timeout = 1'b0 & HoldCfgValid;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      Grant    <= '0;
      GrantIdx <= '0;
      BusBusy  <= 1'b0;
      last_idx <= LastReset;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      Timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      // Timeout is a single-clock pulse, cleared whether or not Tick is high.
      Timeout <= 1'b0;
`endif
      if (Tick) begin
        case (state)
          IDLE: begin
            if (next_found) begin
              Grant    <= OneHotLsb << next_idx;
              GrantIdx <= next_idx;
              last_idx <= next_idx;
              BusBusy  <= 1'b1;
              state    <= GRANT;
`ifdef ARB_TIMEOUT_EN
              hold_cnt <= '0;
`endif
            end
          end
          GRANT: begin
            // Done/Req-drop release wins over the hold limit and suppresses Timeout.
            if (owner_done || !owner_req) begin
              Grant    <= '0;
              GrantIdx <= '0;
              state    <= RELEASE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt == TimeoutLast) begin
              Grant    <= '0;
              GrantIdx <= '0;
              Timeout  <= 1'b1;
              state    <= RELEASE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
`endif
          end
          RELEASE: begin
            // Turnaround tick: no driver on the bus, arbitration resumes next tick.
            BusBusy <= 1'b0;
            state   <= IDLE;
          end
          default: begin
            Grant    <= '0;
            GrantIdx <= '0;
            BusBusy  <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_register_bus_arbiter.sv
// tb/tb_register_bus_arbiter.sv - self-checking bench for register_bus_arbiter
module tb_register_bus_arbiter;
  localparam int N  = 4;
  localparam int GT = 15;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Tick  = 1'b1;
  logic [N-1:0] Req   = '0;
  logic [N-1:0] Done;
  logic [N-1:0] Grant;
  logic [N-1:0] Cs;
  logic [1:0]   GrantIdx;
  logic         BusBusy;
  logic         Timeout;

  int checks = 0;
  int errors = 0;

  // stimulus helpers
  int           done_after  = 0;
  logic [N-1:0] done_auto   = '0;
  logic [N-1:0] done_manual = '0;
  int           own_cnt     = 0;
  int           tick_mode   = 0;
  int           clk_n       = 0;
  int           tick_edges  = 0;
  bit           to_seen     = 1'b0;
  int           dut_order[$];
  int           model_order[$];
  logic [N-1:0] prev_grant  = '0;

  // behavioural model: who owns the bus, how long, and whether we are in the gap
  int  m_owner = -1;
  int  m_last  = N - 1;
  int  m_held  = 0;
  bit  m_turn  = 1'b0;
  bit  m_to    = 1'b0;
  bit  m_found;
  int  m_c;

  logic [N-1:0] exp_grant;
  logic [N-1:0] exp_cs;

  assign Done = (done_after != 0) ? done_auto : done_manual;

  register_bus_arbiter #(
    .NrOfRequesters(N),
    .IdxBits(2),
    .GrantTimeout(GT),
    .CntBits(8)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Tick(Tick),
    .Req(Req),
    .Done(Done),
    .Grant(Grant),
    .Cs(Cs),
    .GrantIdx(GrantIdx),
    .BusBusy(BusBusy),
    .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Tick pattern: always high, or high one clock in four.
  always @(negedge Clock) begin
    clk_n++;
    Tick = (tick_mode == 0) ? 1'b1 : ((clk_n % 4) == 0);
  end

  always @(posedge Clock) if (Tick) tick_edges++;

  // Owner pulses Done on the done_after-th tick of its ownership.
  always @(negedge Clock) begin
    if (Grant != '0) own_cnt++;
    else own_cnt = 0;
    done_auto = (own_cnt == done_after) ? Grant : '0;
  end

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_owner = -1;
      m_last  = N - 1;
      m_held  = 0;
      m_turn  = 1'b0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (Tick) begin
        if (m_turn) begin
          m_turn = 1'b0;
        end else if (m_owner < 0) begin
          m_found = 1'b0;
          for (int i = 1; i <= N; i++) begin
            m_c = (m_last + i) % N;
            if (!m_found && Req[m_c]) begin
              m_found = 1'b1;
              m_owner = m_c;
              m_last  = m_c;
              m_held  = 0;
              model_order.push_back(m_c);
            end
          end
        end else begin
          m_held++;
          if (Done[m_owner] || !Req[m_owner]) begin
            m_owner = -1;
            m_turn  = 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          else if (m_held == GT) begin
            m_owner = -1;
            m_turn  = 1'b1;
            m_to    = 1'b1;
          end
`endif
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clock) begin
    if (Reset) begin
      prev_grant = '0;
    end else begin
      exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      exp_cs    = ~exp_grant;
      chk("grant", int'(Grant), int'(exp_grant));
      chk("cs", int'(Cs), int'(exp_cs));
      chk("grant_idx", int'(GrantIdx), (m_owner >= 0) ? m_owner : 0);
      chk("bus_busy", int'(BusBusy), int'(m_owner >= 0 || m_turn));
      chk("timeout", int'(Timeout), int'(m_to));
      if (Timeout) to_seen = 1'b1;
      if (Grant != '0 && prev_grant == '0) dut_order.push_back(int'(GrantIdx));
      prev_grant = Grant;
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    dut_order.delete();
    model_order.delete();
    Reset = 1'b0;
  endtask

  task automatic wait_grant(input int bound, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < bound) begin
      @(negedge Clock);
      n++;
      ok = (Grant != '0);
    end
  endtask

  task automatic chk_order(input string name, input int e0, input int e1,
                           input int e2, input int e3, input int e4, input int len);
    int exp_seq[5];
    exp_seq = '{e0, e1, e2, e3, e4};
    chk({name, "_len"}, int'(dut_order.size() >= len), 1);
    chk({name, "_model_len"}, int'(model_order.size() >= len), 1);
    for (int i = 0; i < len; i++) begin
      if (i < dut_order.size()) chk({name, "_dut"}, dut_order[i], exp_seq[i]);
      if (i < model_order.size()) chk({name, "_model"}, model_order[i], exp_seq[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    int t0;

    // reset state and idle stability
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_grant", int'(Grant), 0);
    chk("rst_cs", int'(Cs), 15);
    chk("rst_idx", int'(GrantIdx), 0);
    chk("rst_busy", int'(BusBusy), 0);
    chk("rst_timeout", int'(Timeout), 0);
    repeat (10) @(negedge Clock);
    chk("idle_grant", int'(Grant), 0);
    chk("idle_cs", int'(Cs), 15);

    // asynchronous reset while a grant is held
    Req = 4'b0001;
    wait_grant(10, n, ok);
    chk("mid_grant_setup", int'(ok), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_cs", int'(Cs), 15);
    chk("async_grant", int'(Grant), 0);
    Req = '0;
    @(negedge Clock);
    Reset = 1'b0;

    // two requesters, Done on 3rd owned tick
    do_reset();
    Req        = 4'b0101;
    done_after = 3;
    repeat (24) @(negedge Clock);
    chk_order("order_0101", 0, 2, 0, 2, 0, 4);
    Req = '0;
    repeat (6) @(negedge Clock);

    // all requesting, Done on 2nd owned tick
    do_reset();
    Req        = 4'b1111;
    done_after = 2;
    repeat (22) @(negedge Clock);
    chk_order("order_1111", 0, 1, 2, 3, 0, 5);
    Req = '0;
    repeat (6) @(negedge Clock);
    done_after = 0;

    // hold limit
    do_reset();
    Req     = 4'b0010;
    to_seen = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_grant(5, n, ok);
    chk("to_grant_ok", int'(ok), 1);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge Clock);
      n++;
      ok = Timeout;
    end
    chk("to_ticks", n, 15);
    chk("to_grant_off", int'(Grant), 0);
    @(negedge Clock);
    chk("to_width", int'(Timeout), 0);
    chk("to_gap_grant", int'(Grant), 0);
    wait_grant(5, n, ok);
    chk("regrant_ok", int'(ok), 1);
    chk("regrant_wait", n, 1);
    chk("regrant_idx", int'(GrantIdx), 1);
`else
    repeat (110) @(negedge Clock);
    chk("held_grant", int'(Grant), 2);
    chk("no_timeout", int'(to_seen), 0);
`endif
    Req = '0;
    repeat (4) @(negedge Clock);

    // sparse Tick
    do_reset();
    tick_mode = 1;
    repeat (4) @(negedge Clock);
    Req = 4'b1000;
    t0  = tick_edges;
    wait_grant(20, n, ok);
    chk("tick_grant_ok", int'(ok), 1);
    chk("tick_latency", tick_edges - t0, 1);
    repeat (16) @(negedge Clock);
    chk("tick_held", int'(Grant), 8);
    Req = '0;
    t0  = tick_edges;
    n   = 0;
    while (BusBusy && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk("tick_release", tick_edges - t0, 2);
    tick_mode = 0;
    repeat (4) @(negedge Clock);

    // Done from a non-owner is ignored
    do_reset();
    Req = 4'b1000;
    wait_grant(5, n, ok);
    chk("foreign_setup", int'(ok), 1);
    done_manual = 4'b0010;
    repeat (3) @(negedge Clock);
    chk("foreign_done", int'(Grant), 8);
    done_manual = '0;

    // owner Done on the same tick as the hold limit
    do_reset();
    Req = 4'b1000;
    wait_grant(5, n, ok);
    chk("limit_setup", int'(ok), 1);
    repeat (14) @(negedge Clock);
    done_manual = 4'b1000;
    @(negedge Clock);
    chk("limit_grant", int'(Grant), 0);
    chk("limit_timeout", int'(Timeout), 0);
    done_manual = '0;
    Req         = '0;
    repeat (4) @(negedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
